// File: rtl/dm_sram_bridge.sv
// Data-side bridge: turns Execute-stage load/store requests into a single outstanding SRAM-like
// transaction, stalls the pipeline while it runs, and returns load data. Optional DM_PERF_CNT_EN.
module dm_sram_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Clr_n,
    input  logic                  exp_flush,
    input  logic                  E_now_exp,
    input  logic                  E_MemReadEnable,
    input  logic [DATA_W/8-1:0]   E_MemWriteEnable,
    input  logic [1:0]            E_MemSize,
    input  logic [ADDR_W-1:0]     E_calLSaddr,
    input  logic [DATA_W-1:0]     E_WriteMemData,
    output logic                  data_sram_req,
    output logic                  data_sram_wr,
    output logic [1:0]            data_sram_size,
    output logic [ADDR_W-1:0]     data_sram_addr,
    output logic [DATA_W/8-1:0]   data_sram_wstrb,
    output logic [DATA_W-1:0]     data_sram_wdata,
    input  logic                  data_sram_addr_ok,
    input  logic                  data_sram_data_ok,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  dm_stall,
    output logic [DATA_W-1:0]     M_ReadData,
    output logic                  M_ReadValid
`ifdef DM_PERF_CNT_EN
    ,
    output logic [31:0]           dm_stall_cycles,
    output logic [31:0]           dm_txn_count
`endif
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                drop_reg, drop_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [1:0]          size_reg;
    logic                wr_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic mem_req;
    logic issue_ok;
    logic is_store;
    logic capture;
    logic drop_eff;
    logic load_ret;

    assign is_store = |E_MemWriteEnable;
    assign mem_req  = E_MemReadEnable | is_store;
    assign issue_ok = mem_req & ~E_now_exp & ~exp_flush;
    assign capture  = (state_reg == S_IDLE) & issue_ok;
    // A flush arriving in the same cycle as data_ok still discards the result.
    assign drop_eff = drop_reg | exp_flush;
    assign load_ret = (state_reg == S_WAIT) & data_sram_data_ok & ~drop_eff & ~wr_reg;

    // State register
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_reg <= S_IDLE;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        case (state_reg)
            S_IDLE: begin
                drop_next = 1'b0;
                if (issue_ok)
                    state_next = data_sram_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                if (exp_flush)
                    drop_next = 1'b1;
                if (data_sram_addr_ok)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    state_next = drop_eff ? S_IDLE : S_DONE;
                    drop_next  = 1'b0;
                end else if (exp_flush) begin
                    drop_next = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                drop_next  = 1'b0;
            end
        endcase
    end

    // Request fields are latched on every issue so REQ can replay them and DONE knows load vs store.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            size_reg  <= 2'd0;
            wr_reg    <= 1'b0;
        end else if (capture) begin
            addr_reg  <= E_calLSaddr;
            wdata_reg <= E_WriteMemData;
            wstrb_reg <= E_MemWriteEnable;
            size_reg  <= E_MemSize;
            wr_reg    <= is_store;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n)
            rdata_reg <= '0;
        else if (load_ret)
            rdata_reg <= data_sram_rdata;
    end

    assign M_ReadData = rdata_reg;

    // Output logic; everything is forced low while reset is held, even if E presents a request.
    always_comb begin
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'd0;
        data_sram_addr  = '0;
        data_sram_wstrb = '0;
        data_sram_wdata = '0;
        dm_stall        = 1'b0;
        M_ReadValid     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (issue_ok) begin
                    data_sram_req   = 1'b1;
                    data_sram_wr    = is_store;
                    data_sram_size  = E_MemSize;
                    data_sram_addr  = E_calLSaddr;
                    data_sram_wstrb = E_MemWriteEnable;
                    data_sram_wdata = E_WriteMemData;
                end
                dm_stall = issue_ok;
            end
            S_REQ: begin
                data_sram_req   = 1'b1;
                data_sram_wr    = wr_reg;
                data_sram_size  = size_reg;
                data_sram_addr  = addr_reg;
                data_sram_wstrb = wstrb_reg;
                data_sram_wdata = wdata_reg;
                dm_stall        = drop_reg ? mem_req : 1'b1;
            end
            S_WAIT: begin
                dm_stall = drop_reg ? mem_req : 1'b1;
            end
            S_DONE: begin
                M_ReadValid = ~wr_reg;
            end
            default: begin
                dm_stall = 1'b0;
            end
        endcase
        if (!Clr_n) begin
            data_sram_req   = 1'b0;
            data_sram_wr    = 1'b0;
            data_sram_size  = 2'd0;
            data_sram_addr  = '0;
            data_sram_wstrb = '0;
            data_sram_wdata = '0;
            dm_stall        = 1'b0;
            M_ReadValid     = 1'b0;
        end
    end

`ifdef DM_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] txn_cnt_reg;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            stall_cnt_reg <= 32'd0;
            txn_cnt_reg   <= 32'd0;
        end else begin
            if (dm_stall)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (data_sram_req && data_sram_addr_ok)
                txn_cnt_reg <= txn_cnt_reg + 32'd1;
        end
    end

    assign dm_stall_cycles = stall_cnt_reg;
    assign dm_txn_count    = txn_cnt_reg;
`endif

endmodule
